// File: rtl/max_pool_unit.sv
// max_pool_unit: 2x2 stride-2 signed max pooling over a 3-channel row-pair stream
module max_pool_unit #(
  parameter int BD     = 18,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ready_in,
  input  logic [BD-1:0] q0_c0,
  input  logic [BD-1:0] q0_c1,
  input  logic [BD-1:0] q0_c2,
  input  logic [BD-1:0] q1_c0,
  input  logic [BD-1:0] q1_c1,
  input  logic [BD-1:0] q1_c2,
  output logic          mpen,
  output logic [10:0]   rdaddr,
  output logic          wren,
  output logic [10:0]   wraddr,
  output logic [BD-1:0] d_c0,
  output logic [BD-1:0] d_c1,
  output logic [BD-1:0] d_c2,
  output logic [1:0]    bram_num,
  output logic          next_st
);
  localparam int N  = IMG_H / 2 * IMG_W;
  localparam int OW = IMG_W / 2;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  state_t state;
  logic [RD_LAT-1:0] vld;
  logic ph, last;
  logic [10:0] wj, wp;
  logic signed [BD-1:0] v [3];
  logic signed [BD-1:0] m [3];
  function automatic logic signed [BD-1:0] smax(input logic signed [BD-1:0] a, input logic signed [BD-1:0] b);
    return a > b ? a : b;
  endfunction
  // vertical max of the current even/odd row pair, per channel
  always_comb begin
    m[0] = smax(q0_c0, q1_c0);
    m[1] = smax(q0_c1, q1_c1);
    m[2] = smax(q0_c2, q1_c2);
  end
  // sequencer: issues N reads, then waits for the final write before signalling done
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= IDLE;
      mpen    <= 1'b0;
      rdaddr  <= '0;
      next_st <= 1'b0;
    end else
      case (state)
        IDLE:  if (ready_in) begin
          state <= READ;
          mpen  <= 1'b1;
        end
        READ:  if (rdaddr == 11'(N - 1)) begin
          state  <= DRAIN;
          mpen   <= 1'b0;
          rdaddr <= '0;
        end else rdaddr <= rdaddr + 11'd1;
        DRAIN: if (wren && last) begin
          state   <= DONE;
          next_st <= 1'b1;
        end
        DONE: begin
          state   <= IDLE;
          next_st <= 1'b0;
        end
        default: state <= IDLE;
      endcase
  // delay read enables to match data latency; even columns seed v, odd columns emit a write
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      vld      <= '0;
      ph       <= 1'b0;
      wren     <= 1'b0;
      last     <= 1'b0;
      wj       <= '0;
      wp       <= '0;
      wraddr   <= '0;
      bram_num <= '0;
      d_c0     <= '0;
      d_c1     <= '0;
      d_c2     <= '0;
      for (int c = 0; c < 3; c++) v[c] <= '0;
    end else begin
      vld[0] <= mpen;
      for (int i = 1; i < RD_LAT; i++) vld[i] <= vld[i-1];
      wren <= vld[RD_LAT-1] && ph;
      if (vld[RD_LAT-1]) begin
        ph <= ~ph;
        if (!ph)
          for (int c = 0; c < 3; c++) v[c] <= m[c];
        else begin
          d_c0     <= smax(v[0], m[0]);
          d_c1     <= smax(v[1], m[1]);
          d_c2     <= smax(v[2], m[2]);
          bram_num <= wp[1:0];
          wraddr   <= 11'((wp >> 2) * OW) + wj;
          last     <= (wp == 11'(IMG_H / 2 - 1)) && (wj == 11'(OW - 1));
          wj       <= (wj == 11'(OW - 1)) ? '0 : wj + 11'd1;
          wp       <= (wj != 11'(OW - 1)) ? wp : (wp == 11'(IMG_H / 2 - 1)) ? '0 : wp + 11'd1;
        end
      end
    end
endmodule

// File: tb/tb_max_pool_unit.sv
// tb_max_pool_unit: scoreboard bench over three geometries/latencies of max_pool_unit
module tb_max_pool_unit;
  localparam int BD = 18;
  typedef struct packed {
    logic [1:0]           b;
    logic [10:0]          wa;
    logic [2:0][BD-1:0]   d;
  } wr_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ready_in = 1'b0;
  logic arm = 1'b0;
  logic clr = 1'b0;
  int mode = 0;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int snap;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic signed [BD-1:0] smax(input logic signed [BD-1:0] a, input logic signed [BD-1:0] b);
    return a > b ? a : b;
  endfunction
  function automatic logic signed [BD-1:0] val(input int c, input int port, input int a);
    int h;
    if (mode == 0) begin
      if (c == 0) return BD'(a + 100 * port);
      if (c == 1) return BD'(port != 0 ? -3 : -5);
      return BD'(7);
    end
    h = a * 1103515245 + c * 12345 + port * 777;
    h = h ^ (h >>> 13);
    return BD'(h);
  endfunction
  for (genvar g = 0; g < 3; g++) begin : g_u
    localparam int H = g == 1 ? 10 : 4;
    localparam int L = g == 2 ? 2 : 1;
    logic mpen, wren, next_st;
    logic [10:0] rdaddr, wraddr, ra;
    logic [1:0] bram_num;
    logic [BD-1:0] q0 [3];
    logic [BD-1:0] q1 [3];
    logic [BD-1:0] d [3];
    logic [10:0] ad [L];
    wr_t q[$];
    wr_t e;
    int a, nrd, nwr, nns;
    int first_wr = -1;
    int last_wr = -1;
    max_pool_unit #(.BD(BD), .IMG_W(4), .IMG_H(H), .RD_LAT(L)) dut (
      .clk(clk), .reset(reset), .ready_in(ready_in),
      .q0_c0(q0[0]), .q0_c1(q0[1]), .q0_c2(q0[2]),
      .q1_c0(q1[0]), .q1_c1(q1[1]), .q1_c2(q1[2]),
      .mpen(mpen), .rdaddr(rdaddr), .wren(wren), .wraddr(wraddr),
      .d_c0(d[0]), .d_c1(d[1]), .d_c2(d[2]),
      .bram_num(bram_num), .next_st(next_st)
    );
    always @(posedge clk) begin
      ad[0] <= rdaddr;
      for (int i = 1; i < L; i++) ad[i] <= ad[i-1];
    end
    always_comb
      for (int c = 0; c < 3; c++) begin
        q0[c] = val(c, 0, int'(ad[L-1]));
        q1[c] = val(c, 1, int'(ad[L-1]));
      end
    initial forever begin
      @(negedge clk);
      if (clr) begin
        q.delete();
        nrd = 0;
        nwr = 0;
        nns = 0;
        ra = '0;
        first_wr = -1;
        last_wr = -1;
      end
      if (arm)
        for (int p = 0; p < H / 2; p++)
          for (int j = 0; j < 2; j++) begin
            a = p * 4 + 2 * j;
            e.b = 2'(p % 4);
            e.wa = 11'((p / 4) * 2 + j);
            for (int c = 0; c < 3; c++)
              e.d[c] = smax(smax(val(c, 0, a), val(c, 1, a)), smax(val(c, 0, a + 1), val(c, 1, a + 1)));
            q.push_back(e);
          end
      if (mpen) begin
        check($sformatf("u%0d rdaddr", g), rdaddr, ra);
        ra++;
        nrd++;
      end
      if (wren) begin
        check($sformatf("u%0d write expected", g), q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check($sformatf("u%0d w%0d bram_num", g, nwr), bram_num, e.b);
          check($sformatf("u%0d w%0d wraddr", g, nwr), wraddr, e.wa);
          for (int c = 0; c < 3; c++)
            check($sformatf("u%0d w%0d d_c%0d", g, nwr, c), d[c], e.d[c]);
        end
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
        nwr++;
      end
      if (next_st) begin
        nns++;
        check($sformatf("u%0d next_st after last wren", g), cyc - last_wr, 1);
      end
    end
  end
  task automatic start(input bit dup);
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0; ready_in = 1'b1; arm = 1'b1;
    @(posedge clk); #1 ready_in = 1'b0; arm = 1'b0;
    if (dup) begin
      repeat (3) @(posedge clk);
      #1 ready_in = 1'b1;
      @(posedge clk); #1 ready_in = 1'b0;
    end
  endtask
  task automatic finish_run(input string tag);
    for (int i = 0; i < 300 && !(g_u[0].nns > 0 && g_u[1].nns > 0 && g_u[2].nns > 0); i++) @(posedge clk);
    repeat (6) @(posedge clk);
    check({tag, " u0 reads"}, g_u[0].nrd, 8);
    check({tag, " u0 writes"}, g_u[0].nwr, 4);
    check({tag, " u0 next_st count"}, g_u[0].nns, 1);
    check({tag, " u0 leftover"}, g_u[0].q.size(), 0);
    check({tag, " u1 reads"}, g_u[1].nrd, 20);
    check({tag, " u1 writes"}, g_u[1].nwr, 10);
    check({tag, " u1 next_st count"}, g_u[1].nns, 1);
    check({tag, " u1 leftover"}, g_u[1].q.size(), 0);
    check({tag, " u2 reads"}, g_u[2].nrd, 8);
    check({tag, " u2 writes"}, g_u[2].nwr, 4);
    check({tag, " u2 next_st count"}, g_u[2].nns, 1);
    check({tag, " u2 leftover"}, g_u[2].q.size(), 0);
    check({tag, " latency step"}, g_u[2].first_wr - g_u[0].first_wr, 1);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 check("reset outputs", {g_u[0].mpen, g_u[0].rdaddr, g_u[0].wren, g_u[0].wraddr, g_u[0].bram_num, g_u[0].next_st}, 0);
    check("reset data", {g_u[0].d[0], g_u[0].d[1], g_u[0].d[2]}, 0);
    reset = 1'b0;
    start(0);
    finish_run("pattern");
    mode = 1;
    start(0);
    finish_run("random");
    mode = 0;
    start(1);
    finish_run("dup ready");
    start(0);
    repeat (6) @(posedge clk);
    #2 reset = 1'b1;
    #1 check("mid reset outputs", {g_u[0].mpen, g_u[0].rdaddr, g_u[0].wren, g_u[0].wraddr, g_u[0].bram_num, g_u[0].next_st}, 0);
    check("mid reset data", {g_u[0].d[0], g_u[0].d[1], g_u[0].d[2]}, 0);
    snap = g_u[0].nwr;
    check("writes before reset", snap > 0, 1);
    @(posedge clk); #1 reset = 1'b0;
    repeat (30) @(posedge clk);
    check("no writes after reset", g_u[0].nwr, snap);
    check("u0 no next_st after reset", g_u[0].nns, 0);
    check("u1 no next_st after reset", g_u[1].nns, 0);
    check("u2 no next_st after reset", g_u[2].nns, 0);
    check("idle after reset", g_u[0].mpen, 0);
    start(0);
    finish_run("post reset");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/max_pool_unit.md
Name: max_pool_unit

Overview:
- 2x2, stride-2 max-pooling stage between a convolution layer's intermediate buffer and the next layer's line buffers.
- Streams row pairs of a 3-channel feature map from two row-interleaved BRAM read ports (even rows on q0, odd rows on q1).
- Computes the signed maximum of each 2x2 window per channel.
- Writes results round-robin into four output BRAMs, one output row per BRAM; pulses next_st when the whole map is done.

Parameters:
- BD, 18, data width per channel, signed two's complement.
- IMG_W, 32, input map width in pixels; must be even.
- IMG_H, 32, input map height in pixels; must be even.
- RD_LAT, 1, upstream BRAM read latency in cycles.

Ports:
- clk  in  1  clock; everything on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ready_in  in  1  start pulse; full input map available.
- q0_c0, q0_c1, q0_c2  in  BD  even-row data, channels 0..2.
- q1_c0, q1_c1, q1_c2  in  BD  odd-row data, channels 0..2.
- mpen  out  1  read enable to both input BRAM ports.
- rdaddr  out  11  read address, shared by both ports.
- wren  out  1  output write strobe.
- wraddr  out  11  output write address.
- d_c0, d_c1, d_c2  out  BD  pooled data, channels 0..2.
- bram_num  out  2  target output BRAM, 0..3.
- next_st  out  1  one-cycle done pulse.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0; internal channel registers cleared. Reset is asynchronous and may occur mid-operation; after release the block waits for a new ready_in, with no partial writes or next_st.
- Address map: input pair p (rows 2p, 2p+1) at column c is at rdaddr = p*IMG_W + c. Total reads N = (IMG_H/2)*IMG_W.
- States: IDLE -> READ -> DRAIN -> DONE -> IDLE.
- IDLE: ready_in sampled high moves to READ. ready_in in any other state is ignored.
- READ: mpen=1 for exactly N consecutive cycles, with rdaddr = 0,1,...,N-1, one per cycle (registered outputs). After the last address, go to DRAIN.
- DRAIN: mpen=0, rdaddr holds 0. Wait until the final write has issued, then go to DONE.
- DONE: next_st=1 for exactly one cycle, then IDLE.
- Data pipeline:
  - Data for address a appears on q* RD_LAT cycles after the cycle in which rdaddr=a with mpen=1.
  - Even column (c=2j): register v = max(q0,q1) per channel.
  - Odd column (c=2j+1): compute max(v, max(q0,q1)) and register it into d_c*.
  - wren=1 for one cycle with the registered data, i.e. one cycle after the odd-column data is valid. wren therefore pulses every second cycle during streaming.
- Comparisons are signed. Ties select either operand (identical value).
- Write addressing for pair p, output column j (0..IMG_W/2-1):
  - bram_num = p mod 4.
  - wraddr = (p div 4)*(IMG_W/2) + j.
  - bram_num and wraddr are valid, and stable, in the same cycle as wren.
- d_c*, wraddr, and bram_num hold their last values when wren=0.
- Total wren pulses = (IMG_H/2)*(IMG_W/2).
- next_st asserts one cycle after the last wren.
- A new ready_in accepted in IDLE right after DONE restarts cleanly from address 0 and bram_num 0.

Test Plan:
1. IMG_W=4, IMG_H=4, RD_LAT=1. BRAM model returns q0_c0=addr, q1_c0=addr+100. Pulse ready_in -> mpen high for 8 cycles with rdaddr 0..7. Four wren pulses with (bram_num, wraddr, d_c0) = (0,0,101), (0,1,103), (1,0,105), (1,1,107). next_st pulses once, one cycle after the 4th wren.
2. Same run with q0_c1=-5, q1_c1=-3 constant and q0_c2=q1_c2=7 -> every write has d_c1=-3 (0x3FFFD) and d_c2=7.
3. IMG_H=10, IMG_W=4 -> pairs 0..4 give bram_num 0,1,2,3,0. Pair 4 writes wraddr 2,3. 10 wren pulses total.
4. Pulse ready_in again during READ -> ignored; rdaddr sequence and write count unchanged.
5. Assert reset during READ -> all outputs 0 immediately, with no further wren or next_st. A subsequent ready_in reproduces scenario 1 exactly.
6. RD_LAT=2 with scenario 1 data -> identical write values and addresses. The first wren is one cycle later than with RD_LAT=1.
